// File: rtl/uart_rx_if.sv
// Signal bundle between the RX pin synchroniser side and the UART receive controller.
// brk_det exists only when UART_RX_BREAK_DETECT_EN is defined.
interface uart_rx_if #(
  parameter int DATA_MAX   = 9,
  parameter int PRESCALE_W = 6
);
  logic                  rx_in;
  logic [PRESCALE_W-1:0] prescale;
  logic [3:0]            data_len;
  logic                  par_en;
  logic                  par_typ;
  logic                  stop2;
  logic [DATA_MAX-1:0]   p_data;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;
  logic                  busy;
  logic [2:0]            state_dbg;
`ifdef UART_RX_BREAK_DETECT_EN
  logic                  brk_det;
`endif

  // data_valid, par_err, stp_err (and brk_det) are one-cycle strobes with no ready:
  // the consumer must capture p_data in the data_valid cycle; there is no backpressure.
  modport master (
    output rx_in, prescale, data_len, par_en, par_typ, stop2,
    input  p_data, data_valid, par_err, stp_err, busy, state_dbg
`ifdef UART_RX_BREAK_DETECT_EN
    , input brk_det
`endif
  );

  modport slave (
    input  rx_in, prescale, data_len, par_en, par_typ, stop2,
    output p_data, data_valid, par_err, stp_err, busy, state_dbg
`ifdef UART_RX_BREAK_DETECT_EN
    , output brk_det
`endif
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: oversampled 3-sample majority vote, parity and stop checking.
// Define UART_RX_BREAK_DETECT_EN to add break detection (brk_det output, BREAK state).
module uart_rx_ctrl #(
  parameter int DATA_MAX   = 9,
  parameter int PRESCALE_W = 6
) (
  input logic      clk,
  input logic      rst,
  uart_rx_if.slave bus
);
  localparam logic [PRESCALE_W-1:0] P_ONE   = PRESCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] P_MIN   = PRESCALE_W'(4);
  localparam logic [3:0]            LEN_MIN = 4'd5;
  localparam logic [3:0]            LEN_MAX = 4'(DATA_MAX);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
`ifdef UART_RX_BREAK_DETECT_EN
    , S_BREAK = 3'd5
`endif
  } state_t;

  state_t                state_q, state_d;
  logic [PRESCALE_W-1:0] cnt_q, cnt_d, pre_q, pre_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d, len_q, len_d;
  logic                  par_en_q, par_en_d, par_typ_q, par_typ_d, stop2_q, stop2_d;
  logic [DATA_MAX-1:0]   shadow_q, shadow_d, p_data_q, p_data_d;
  logic                  s0_q, s0_d, s1_q, s1_d, s2_q, s2_d;
  logic                  perr_q, perr_d, serr_q, serr_d;
  logic                  dv_q, dv_d, par_err_q, par_err_d, stp_err_q, stp_err_d;
  logic                  busy_q, busy_d;
`ifdef UART_RX_BREAK_DETECT_EN
  logic                  brk_q, brk_d, pbit_q, pbit_d, fstop0_q, fstop0_d;
  logic                  first_stop0;
`endif

  logic [PRESCALE_W-1:0] pre_in, half, last;
  logic [3:0]            len_in;
  logic                  s2_eff, bit_val, wrap, launch, stop_bad, last_stop;

  assign pre_in = (bus.prescale < P_MIN) ? P_MIN : bus.prescale;
  assign len_in = (bus.data_len < LEN_MIN) ? LEN_MIN :
                  (bus.data_len > LEN_MAX) ? LEN_MAX : bus.data_len;
  assign half   = pre_q >> 1;
  assign last   = pre_q - P_ONE;
  assign wrap   = (cnt_q == last);
  // At prescale 4 the third sample lands on the evaluation edge, so use the live line.
  assign s2_eff  = (cnt_q == half + P_ONE) ? bus.rx_in : s2_q;
  assign bit_val = (s0_q & s1_q) | (s0_q & s2_eff) | (s1_q & s2_eff);

  always_comb begin
    state_d   = state_q;
    cnt_d     = wrap ? '0 : cnt_q + P_ONE;
    bit_cnt_d = wrap ? bit_cnt_q + 4'd1 : bit_cnt_q;
    pre_d     = pre_q;
    len_d     = len_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    stop2_d   = stop2_q;
    shadow_d  = shadow_q;
    p_data_d  = p_data_q;
    s0_d      = s0_q;
    s1_d      = s1_q;
    s2_d      = s2_q;
    perr_d    = perr_q;
    serr_d    = serr_q;
    dv_d      = 1'b0;
    par_err_d = 1'b0;
    stp_err_d = 1'b0;
    launch    = 1'b0;
    stop_bad  = serr_q | ~bit_val;
    last_stop = stop2_q ? (bit_cnt_q == 4'd1) : 1'b1;
`ifdef UART_RX_BREAK_DETECT_EN
    brk_d       = 1'b0;
    pbit_d      = pbit_q;
    fstop0_d    = fstop0_q;
    first_stop0 = (bit_cnt_q == 4'd0) ? ~bit_val : fstop0_q;
`endif

    if (state_q != S_IDLE) begin
      if (cnt_q == half - P_ONE) s0_d = bus.rx_in;
      if (cnt_q == half)         s1_d = bus.rx_in;
      if (cnt_q == half + P_ONE) s2_d = bus.rx_in;
    end

    case (state_q)
      S_IDLE: begin
        cnt_d     = '0;
        bit_cnt_d = '0;
        if (!bus.rx_in) launch = 1'b1;
      end
      S_START: if (wrap) begin
        bit_cnt_d = '0;
        state_d   = bit_val ? S_IDLE : S_DATA;
      end
      S_DATA: if (wrap) begin
        shadow_d[bit_cnt_q] = bit_val;
        if (bit_cnt_q == len_q - 4'd1) begin
          bit_cnt_d = '0;
          state_d   = par_en_q ? S_PARITY : S_STOP;
        end
      end
      // Parity errors are only recorded so the frame stays aligned to its stop bits.
      S_PARITY: if (wrap) begin
        perr_d    = bit_val ^ (^shadow_q) ^ par_typ_q;
`ifdef UART_RX_BREAK_DETECT_EN
        pbit_d    = bit_val;
`endif
        bit_cnt_d = '0;
        state_d   = S_STOP;
      end
      S_STOP: if (wrap) begin
        if (!last_stop) begin
          serr_d = stop_bad;
`ifdef UART_RX_BREAK_DETECT_EN
          fstop0_d = ~bit_val;
`endif
        end else begin
          bit_cnt_d = '0;
`ifdef UART_RX_BREAK_DETECT_EN
          if (shadow_q == '0 && !pbit_q && first_stop0) begin
            brk_d   = 1'b1;
            cnt_d   = '0;
            state_d = S_BREAK;
          end else
`endif
          begin
            dv_d      = !perr_q && !stop_bad;
            par_err_d = perr_q;
            stp_err_d = stop_bad;
            if (!perr_q && !stop_bad) p_data_d = shadow_q;
            // A low line here is already the next start bit.
            if (!bus.rx_in) launch = 1'b1;
            else            state_d = S_IDLE;
          end
        end
      end
`ifdef UART_RX_BREAK_DETECT_EN
      S_BREAK: begin
        bit_cnt_d = '0;
        if (!bus.rx_in) cnt_d = '0;
        else if (wrap)  state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (launch) begin
      state_d   = S_START;
      cnt_d     = '0;
      bit_cnt_d = '0;
      pre_d     = pre_in;
      len_d     = len_in;
      par_en_d  = bus.par_en;
      par_typ_d = bus.par_typ;
      stop2_d   = bus.stop2;
      shadow_d  = '0;
      perr_d    = 1'b0;
      serr_d    = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      pbit_d    = 1'b0;
      fstop0_d  = 1'b0;
`endif
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      pre_q     <= P_MIN;
      len_q     <= LEN_MIN;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      stop2_q   <= 1'b0;
      shadow_q  <= '0;
      p_data_q  <= '0;
      s0_q      <= 1'b1;
      s1_q      <= 1'b1;
      s2_q      <= 1'b1;
      perr_q    <= 1'b0;
      serr_q    <= 1'b0;
      dv_q      <= 1'b0;
      par_err_q <= 1'b0;
      stp_err_q <= 1'b0;
      busy_q    <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      brk_q     <= 1'b0;
      pbit_q    <= 1'b0;
      fstop0_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      pre_q     <= pre_d;
      len_q     <= len_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      stop2_q   <= stop2_d;
      shadow_q  <= shadow_d;
      p_data_q  <= p_data_d;
      s0_q      <= s0_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      perr_q    <= perr_d;
      serr_q    <= serr_d;
      dv_q      <= dv_d;
      par_err_q <= par_err_d;
      stp_err_q <= stp_err_d;
      busy_q    <= busy_d;
`ifdef UART_RX_BREAK_DETECT_EN
      brk_q     <= brk_d;
      pbit_q    <= pbit_d;
      fstop0_q  <= fstop0_d;
`endif
    end
  end

  assign bus.p_data     = p_data_q;
  assign bus.data_valid = dv_q;
  assign bus.par_err    = par_err_q;
  assign bus.stp_err    = stp_err_q;
  assign bus.busy       = busy_q;
  assign bus.state_dbg  = state_q;
`ifdef UART_RX_BREAK_DETECT_EN
  assign bus.brk_det    = brk_q;
`endif
endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Parametrised UART receive controller: frame FSM, oversampling edge counter, bit counter, 3-sample majority vote, deserialiser and error checkers in one block.
- Sits between the RX pin synchroniser and the RX CDC/register-file path.
- Adds runtime-configurable data length, odd/even parity, 1 or 2 stop bits and back-to-back frame reception.

Parameters:
- DATA_MAX, 9, maximum data bits per frame; p_data width.
- PRESCALE_W, 6, width of the prescale input.

Ports:
- clk  input  1  system/UART RX clock.
- rst  input  1  reset; asynchronous, active-high.
- rx_in  input  1  synchronised serial line; idle high.
- prescale  input  PRESCALE_W  oversampling ratio (clocks per bit).
- data_len  input  4  data bits per frame, 5..DATA_MAX.
- par_en  input  1  parity bit present.
- par_typ  input  1  0 = even, 1 = odd.
- stop2  input  1  0 = one stop bit, 1 = two stop bits.
- p_data  output  DATA_MAX  received word, LSB = first data bit, right-justified, unused upper bits 0.
- data_valid  output  1  one-cycle pulse; p_data holds a good frame.
- par_err  output  1  one-cycle pulse; parity mismatch.
- stp_err  output  1  one-cycle pulse; a stop bit sampled 0.
- busy  output  1  high in any state except IDLE.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; counters and shift register cleared. Reset mid-frame aborts the frame, and no pulse is emitted.
- Config latch: prescale, data_len, par_en, par_typ and stop2 are captured on IDLE->START. Changes mid-frame have no effect until the next frame.
- Config clamping:
  - data_len < 5 is treated as 5; data_len > DATA_MAX is treated as DATA_MAX.
  - prescale < 4 is treated as 4.
- Edge counter: counts 0..P-1 (P = latched prescale) in every non-IDLE state and wraps to 0 at P-1.
- Bit counter: increments on each wrap and clears on every state change.
- Bit sampling: each bit value = majority of rx_in at edge counts P/2-1, P/2 and P/2+1 (integer division). Samples are registered.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE: rx_in==0 -> START, edge counter = 0.
  - START: at edge P-1, sampled bit 1 -> IDLE (glitch, no outputs); otherwise -> DATA.
  - DATA: shift sampled bit into p_data shadow LSB-first. At edge P-1 of bit data_len-1 -> PARITY if par_en, else STOP.
  - PARITY: at edge P-1, compare sampled bit against XOR of data bits (^ par_typ). Record mismatch internally, then -> STOP. Never abort; this keeps the frame aligned.
  - STOP: one or two stop bits. At edge P-1 of the last stop bit, evaluate the frame. Then rx_in==0 -> START, with edge counter reset so the edge is not missed; otherwise -> IDLE.
- Outputs are registered and asserted the cycle after the last stop edge P-1:
  - data_valid=1 and p_data updated only if no parity and no stop error; otherwise p_data keeps its previous value.
  - par_err and stp_err pulse independently; both may pulse together.
- Two stop bits: each is checked; either sampled 0 -> stp_err.
- Latency: from the last stop-bit edge P-1 to data_valid = 1 clk.

Optional Feature:
- Macro UART_RX_BREAK_DETECT_EN.
- When defined:
  - Adds output brk_det (1 bit, reset 0).
  - A frame with all data bits 0, parity bit 0 (if enabled) and first stop bit 0 gives one brk_det pulse, in place of stp_err and par_err.
  - The FSM then enters an extra state, BREAK, and waits for rx_in==1 for one full bit time (P clocks) before IDLE. busy stays high in BREAK.
- When undefined: no brk_det port and no BREAK state. Such a frame is reported as stp_err and the FSM resumes normally.

Test Plan:
- 8N1, prescale 8, byte 0xA5 -> one data_valid pulse 80 clk after the start edge (+1), p_data=0x0A5, no errors.
- 7 data bits, even parity, prescale 16, 0x35 with a wrong parity bit -> par_err pulse, no data_valid, p_data unchanged.
- rx_in low for 3 clk then high, prescale 16 -> back to IDLE, busy drops, no pulses.
- 8N1, stop bit driven 0, data 0x3C -> stp_err pulse, no data_valid. With the macro enabled and data 0x00 -> brk_det only.
- Two back-to-back 9-bit frames, odd parity, stop2=1, prescale 8, data 0x1FF then 0x001, no idle gap -> two data_valid pulses with the correct p_data each.
- Assert rst mid-DATA, release, then send 0x55 -> no pulse from the aborted frame, then a clean 0x55 reception.
